// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : Direct-mapped BTB with 2-bit saturating direction counters,
//            combinational fetch-side lookup, decode-side training, and
//            saturating performance counters for resolutions/mispredicts.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_f,
  input  logic [31:0]      pcplus4_f,
  output logic             pred_taken_f,
  output logic [31:0]      pc_pred_f,
  input  logic             cflow_valid,
  input  logic             cflow_taken,
  input  logic             mispredict,
  input  logic [31:0]      pc_d,
  input  logic [31:0]      pc_jump,
  input  logic             stall_d,
  input  logic             flush_btb,
  output logic [CNT_W-1:0] perf_cflow_cnt,
  output logic [CNT_W-1:0] perf_mispred_cnt
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  // Valid bits and counters live in flops (they need reset); tag and target
  // arrays carry no reset so they can map onto distributed RAM.
  logic [BTB_ENTRIES-1:0] r_valid;
  logic [1:0]             r_ctr    [BTB_ENTRIES];
  logic [TAG_W-1:0]       r_tag    [BTB_ENTRIES];
  logic [31:0]            r_target [BTB_ENTRIES];
  logic [CNT_W-1:0]       r_cflow_cnt;
  logic [CNT_W-1:0]       r_mispred_cnt;

  logic [IDX_W-1:0] w_idx_f;
  logic [TAG_W-1:0] w_tag_f;
  logic             w_hit_f;
  logic [IDX_W-1:0] w_idx_d;
  logic [TAG_W-1:0] w_tag_d;
  logic             w_hit_d;
  logic             w_accept;
  logic [1:0]       w_ctr_d;
  logic [1:0]       w_ctr_next;
  logic             w_unused;

  // Byte-offset bits of both PCs carry no information for a 4-byte ISA.
  assign w_unused = ^{pc_f[1:0], pc_d[1:0]};

  assign w_idx_f = pc_f[IDX_W+1:2];
  assign w_tag_f = pc_f[31:IDX_W+2];
  assign w_idx_d = pc_d[IDX_W+1:2];
  assign w_tag_d = pc_d[31:IDX_W+2];

  // A single decode resolution may sit in a stalled stage for many cycles;
  // only the cycle in which it leaves decode trains the table.
  assign w_accept = cflow_valid && !stall_d;

  // Lookup: the valid bit gates the tag compare so unwritten array contents
  // can never produce a prediction.
  always_comb begin
    w_hit_f      = 1'b0;
    pred_taken_f = 1'b0;
    pc_pred_f    = pcplus4_f;
    if (r_valid[w_idx_f]) begin
      w_hit_f = (r_tag[w_idx_f] == w_tag_f);
    end
    pred_taken_f = w_hit_f && r_ctr[w_idx_f][1];
    if (pred_taken_f) begin
      pc_pred_f = r_target[w_idx_f];
    end
  end

  // Training-side hit detection and saturating counter step.
  always_comb begin
    w_hit_d    = 1'b0;
    w_ctr_d    = r_ctr[w_idx_d];
    w_ctr_next = w_ctr_d;
    if (r_valid[w_idx_d]) begin
      w_hit_d = (r_tag[w_idx_d] == w_tag_d);
    end
    if (cflow_taken) begin
      if (w_ctr_d != 2'b11) begin
        w_ctr_next = w_ctr_d + 2'd1;
      end
    end else begin
      if (w_ctr_d != 2'b00) begin
        w_ctr_next = w_ctr_d - 2'd1;
      end
    end
  end

  // Valid bits and direction counters: reset > flush > training.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_ctr[i] <= 2'b01;
      end
    end else if (flush_btb) begin
      r_valid <= '0;
    end else if (w_accept) begin
      if (w_hit_d) begin
        r_ctr[w_idx_d] <= w_ctr_next;
      end else if (cflow_taken) begin
        r_valid[w_idx_d] <= 1'b1;
        r_ctr[w_idx_d]   <= 2'b10;
      end
    end
  end

  // Tag/target write on any taken accept: refreshes the target on a hit and
  // allocates (evicting any alias) on a miss; the tag is unchanged on a hit.
  always_ff @(posedge clk) begin
    if (!reset && !flush_btb && w_accept && cflow_taken) begin
      r_tag[w_idx_d]    <= w_tag_d;
      r_target[w_idx_d] <= pc_jump;
    end
  end

  // Performance counters count every accepted resolution, flush or not,
  // and stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cflow_cnt   <= '0;
      r_mispred_cnt <= '0;
    end else if (w_accept) begin
      if (r_cflow_cnt != c_CNT_MAX) begin
        r_cflow_cnt <= r_cflow_cnt + c_CNT_ONE;
      end
      if (mispredict && (r_mispred_cnt != c_CNT_MAX)) begin
        r_mispred_cnt <= r_mispred_cnt + c_CNT_ONE;
      end
    end
  end

  assign perf_cflow_cnt   = r_cflow_cnt;
  assign perf_mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Purpose  : Directed scoreboard bench for branch_predictor (16 entries,
//            4-bit performance counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_f;
  logic [31:0] pcplus4_f;
  logic        pred_taken_f;
  logic [31:0] pc_pred_f;
  logic        cflow_valid;
  logic        cflow_taken;
  logic        mispredict;
  logic [31:0] pc_d;
  logic [31:0] pc_jump;
  logic        stall_d;
  logic        flush_btb;
  logic [3:0]  perf_cflow_cnt;
  logic [3:0]  perf_mispred_cnt;

  typedef struct packed {
    logic        pred;
    logic [31:0] pc;
    logic [3:0]  cf;
    logic [3:0]  mp;
  } exp_t;

  exp_t  exp_q  [$];
  string name_q [$];
  logic  chk_req = 1'b0;
  int    errors  = 0;
  int    checks  = 0;

  branch_predictor #(
    .BTB_ENTRIES(16),
    .CNT_W      (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_f            (pc_f),
    .pcplus4_f       (pcplus4_f),
    .pred_taken_f    (pred_taken_f),
    .pc_pred_f       (pc_pred_f),
    .cflow_valid     (cflow_valid),
    .cflow_taken     (cflow_taken),
    .mispredict      (mispredict),
    .pc_d            (pc_d),
    .pc_jump         (pc_jump),
    .stall_d         (stall_d),
    .flush_btb       (flush_btb),
    .perf_cflow_cnt  (perf_cflow_cnt),
    .perf_mispred_cnt(perf_mispred_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: pops the oldest expectation whenever a check window is open and
  // compares it against the DUT outputs on the falling edge.
  always @(negedge clk) begin
    if (chk_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: no expected entry queued");
      end else begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (pred_taken_f !== e.pred || pc_pred_f !== e.pc ||
            perf_cflow_cnt !== e.cf || perf_mispred_cnt !== e.mp) begin
          errors++;
          $display("FAIL %s: got pred=%0b pc=%h cf=%0d mp=%0d, want pred=%0b pc=%h cf=%0d mp=%0d",
                   nm, pred_taken_f, pc_pred_f, perf_cflow_cnt, perf_mispred_cnt,
                   e.pred, e.pc, e.cf, e.mp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cflow_valid = 1'b0;
    cflow_taken = 1'b0;
    mispredict  = 1'b0;
    stall_d     = 1'b0;
    flush_btb   = 1'b0;
    pc_d        = 32'h0;
    pc_jump     = 32'h0;
  endtask

  // One accepted resolution trained on the next edge.
  task automatic train(input logic [31:0] pc, input logic taken,
                       input logic [31:0] jump, input logic mp);
    cflow_valid = 1'b1;
    cflow_taken = taken;
    pc_d        = pc;
    pc_jump     = jump;
    mispredict  = mp;
    tick();
    idle();
  endtask

  // Queue an expectation and open a one-cycle check window for the monitor.
  task automatic check(input string nm, input logic [31:0] pcf, input logic pred,
                       input logic [31:0] pcp, input int cf, input int mp);
    exp_t e;
    pc_f      = pcf;
    pcplus4_f = pcf + 32'd4;
    e.pred    = pred;
    e.pc      = pcp;
    e.cf      = 4'(cf);
    e.mp      = 4'(mp);
    exp_q.push_back(e);
    name_q.push_back(nm);
    chk_req = 1'b1;
    tick();
    chk_req = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    pc_f      = 32'h100;
    pcplus4_f = 32'h104;
    idle();
    tick();
    tick();
    reset = 1'b0;

    check("reset_state", 32'h100, 1'b0, 32'h104, 0, 0);

    // Allocation on a taken miss: weakly taken, target installed.
    train(32'h100, 1'b1, 32'h40, 1'b1);
    check("alloc", 32'h100, 1'b1, 32'h40, 1, 1);

    // Hysteresis: 10 -> 01 -> 00 -> 01 -> 10 -> 11 -> 10.
    train(32'h100, 1'b0, 32'h99, 1'b1);
    check("nt_1", 32'h100, 1'b0, 32'h104, 2, 2);
    train(32'h100, 1'b0, 32'h99, 1'b0);
    check("nt_2", 32'h100, 1'b0, 32'h104, 3, 2);
    train(32'h100, 1'b1, 32'h40, 1'b1);
    check("t_1", 32'h100, 1'b0, 32'h104, 4, 3);
    train(32'h100, 1'b1, 32'h40, 1'b0);
    check("t_2", 32'h100, 1'b1, 32'h40, 5, 3);
    train(32'h100, 1'b1, 32'h48, 1'b0);
    check("t_3_new_target", 32'h100, 1'b1, 32'h48, 6, 3);
    train(32'h100, 1'b0, 32'h99, 1'b0);
    check("hysteresis", 32'h100, 1'b1, 32'h48, 7, 3);

    // Aliasing: 0x140 shares index 0 with 0x100 but has a different tag.
    check("alias_miss", 32'h140, 1'b0, 32'h144, 7, 3);
    train(32'h140, 1'b1, 32'h80, 1'b1);
    check("alias_alloc", 32'h140, 1'b1, 32'h80, 8, 4);
    check("alias_evicted", 32'h100, 1'b0, 32'h104, 8, 4);

    // Stalled decode: three blocked cycles, then one accepted cycle.
    cflow_valid = 1'b1;
    cflow_taken = 1'b1;
    pc_d        = 32'h204;
    pc_jump     = 32'h300;
    stall_d     = 1'b1;
    tick();
    tick();
    check("stall_blocked", 32'h204, 1'b0, 32'h208, 8, 4);
    stall_d = 1'b0;
    tick();
    idle();
    check("stall_one_update", 32'h204, 1'b1, 32'h300, 9, 4);
    train(32'h204, 1'b0, 32'h0, 1'b0);
    check("stall_ctr_weak", 32'h204, 1'b0, 32'h208, 10, 4);

    // Flush beats a same-cycle taken accept, but the accept is still counted.
    flush_btb = 1'b1;
    train(32'h308, 1'b1, 32'h500, 1'b1);
    check("flush_old_entry", 32'h140, 1'b0, 32'h144, 11, 5);
    check("flush_drops_train", 32'h308, 1'b0, 32'h30C, 11, 5);

    // Saturation of both 4-bit performance counters.
    for (int i = 0; i < 3; i++) train(32'h400, 1'b0, 32'h0, 1'b1);
    check("perf_near_max", 32'h100, 1'b0, 32'h104, 14, 8);
    for (int i = 0; i < 17; i++) train(32'h400, 1'b0, 32'h0, 1'b1);
    check("perf_saturate", 32'h100, 1'b0, 32'h104, 15, 15);

    // Asynchronous reset between edges, while an accept is pending.
    train(32'h100, 1'b1, 32'h40, 1'b0);
    check("pre_reset_entry", 32'h100, 1'b1, 32'h40, 15, 15);
    cflow_valid = 1'b1;
    cflow_taken = 1'b1;
    pc_d        = 32'h100;
    pc_jump     = 32'h40;
    mispredict  = 1'b1;
    reset       = 1'b1;
    check("async_reset", 32'h100, 1'b0, 32'h104, 0, 0);
    idle();
    reset = 1'b0;
    check("post_reset", 32'h100, 1'b0, 32'h104, 0, 0);

    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side producer of `pc_pred_f` / `pred_taken_f`; consumer of the decode-stage resolution signals `cflow_valid`, `cflow_taken`, `mispredict`, `pc_d` and `pc_jump`.
- Direct-mapped branch target buffer (BTB). Each entry has a 2-bit saturating direction counter.
- Lookup is combinational on `pc_f`. Training is synchronous from decode-stage resolution.
- Also keeps saturating performance counters of resolved control flow and mispredicts.

Parameters:
- BTB_ENTRIES, 16, number of BTB entries. Power of two, at least 2. IDX_W = log2(BTB_ENTRIES).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- pc_f  input  32  fetch PC to look up
- pcplus4_f  input  32  fetch PC + 4 (fall-through)
- pred_taken_f  output  1  prediction: taken
- pc_pred_f  output  32  predicted next PC
- cflow_valid  input  1  decode holds a resolved branch/jump
- cflow_taken  input  1  resolved direction
- mispredict  input  1  decode detected a misprediction
- pc_d  input  32  PC of the resolved instruction
- pc_jump  input  32  resolved target
- stall_d  input  1  decode stalled; training is blocked
- flush_btb  input  1  synchronous invalidate of all entries (fence.i)
- perf_cflow_cnt  output  CNT_W  accepted resolutions
- perf_mispred_cnt  output  CNT_W  accepted mispredicts

Behaviour:
- Address split: idx = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] is ignored.
- Entry contents: valid, tag, target[31:0], ctr[1:0].
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag match.
  - pred_taken_f = hit && ctr[1].
  - pc_pred_f = pred_taken_f ? target : pcplus4_f.
- Accept condition: accept = cflow_valid && !stall_d. A stalled decode must not train twice.
- Training on accept, at the entry for pc_d:
  - Hit, taken: ctr increments, saturating at 11; target <= pc_jump.
  - Hit, not taken: ctr decrements, saturating at 00; target unchanged.
  - Miss, taken: allocate. valid=1, tag=pc_d tag, target=pc_jump, ctr=10 (weakly taken). Any aliased entry is overwritten.
  - Miss, not taken: no change.
- Same-cycle lookup and training on the same index: the lookup sees pre-edge contents. No bypass; the new value is visible the next cycle.
- Flush: flush_btb clears every valid bit at the edge.
  - Tags, targets and counters are don't-care.
  - Flush has priority over training in the same cycle; that training is dropped.
  - The performance counters still count the accepted resolution.
- Performance counters:
  - On accept, perf_cflow_cnt increments.
  - On accept && mispredict, perf_mispred_cnt increments.
  - Both saturate at all-ones and never wrap.
  - Neither is cleared by flush_btb.
- Reset (asynchronous, any time, including mid-training):
  - All valid = 0, all ctr = 01, perf counters = 0.
  - Outputs immediately become pred_taken_f = 0 and pc_pred_f = pcplus4_f.
  - Target and tag arrays need no reset; they may use distributed RAM with valid held in flops.
- Priority: reset > flush_btb > training.
- No X propagation: a lookup on an invalid entry must give pred_taken_f = 0 regardless of array contents.

Test Plan:
- Reset, pc_f=0x100, pcplus4_f=0x104 -> pred_taken_f=0, pc_pred_f=0x104; both perf counters 0.
- Accept {pc_d=0x100, cflow_taken=1, pc_jump=0x40, mispredict=1} -> next cycle, lookup of 0x100 gives pred_taken_f=1, pc_pred_f=0x40; perf_cflow_cnt=1, perf_mispred_cnt=1.
- Counter hysteresis, continuing from the previous scenario:
  - Two not-taken accepts at 0x100 -> ctr 10→01→00, pred_taken_f=0.
  - Three taken accepts -> ctr saturates at 11.
  - One not-taken accept -> pred_taken_f still 1.
- Aliasing, with BTB_ENTRIES=16: entry 0x100 valid -> lookup 0x140 (same idx, different tag) gives pred_taken_f=0, pc_pred_f=0x144. Taken accept at 0x140 → 0x80 evicts 0x100, so 0x100 then predicts not taken.
- Accept held 3 cycles with stall_d=1, then 1 cycle with stall_d=0 -> exactly one training update; perf_cflow_cnt increments by 1.
- flush_btb in the same cycle as a taken accept -> all lookups give pred_taken_f=0 and perf_cflow_cnt still increments. With CNT_W=4, 20 accepts -> counter holds at 15. Reset asserted mid-sequence clears everything asynchronously.
